// File: rtl/rtc_bus_responder_if.sv
// rtc_bus_if: the strobe half of the multiplexed RTC bus.
//   cs_n  chip select, active low
//   a_d   phase select: 0 address, 1 data
//   wr_n  write strobe, active low
//   rd_n  read strobe, active low (board pull-up makes undriven read as 1)
// The bidirectional ad[7:0] lines stay a plain inout on the responder.
// That keeps the tristate driver and the board-level wire in one visible place.
interface rtc_bus_if;
  logic cs_n;
  logic a_d;
  logic wr_n;
  logic rd_n;

  modport master (output cs_n, a_d, wr_n, rd_n);
  modport slave  (input  cs_n, a_d, wr_n, rd_n);
endinterface

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: device end of the multiplexed address/data RTC bus.
// It decodes address and data phases and holds NREG byte registers.
// Read data is driven back onto ad[7:0].
// On-chip timekeeping logic updates the same registers through a local port.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   bus (rtc_bus_if.slave) cs_n / a_d / wr_n / rd_n strobes
//   ad[7:0]                multiplexed address/data, driven only in READ/DRAIN
//   loc_we/addr/wdata      local write port (bus commit to same reg wins)
//   loc_rdata              registered reg[loc_addr], 0x00 when out of range
//   bus_wr                 one-cycle pulse per committed bus write
//   bus_addr               last latched bus address
//   bus_err                one-cycle pulse per protocol violation
//
// Parameters: NREG (<=256), SYNC (>=2 synchronizer depth), TIMEOUT.
// Optional feature: define RTC_RESP_TIMEOUT_EN to abandon an ARMED
// transaction after TIMEOUT cycles without a further phase.
module rtc_bus_responder #(
  parameter int NREG    = 16,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  rtc_bus_if.slave    bus,
  inout  wire  [7:0]  ad,
  input  logic        loc_we,
  input  logic [7:0]  loc_addr,
  input  logic [7:0]  loc_wdata,
  output logic [7:0]  loc_rdata,
  output logic        bus_wr,
  output logic [7:0]  bus_addr,
  output logic        bus_err
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  if (SYNC < 2) begin : g_bad_sync
    $error("rtc_bus_responder: SYNC must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("rtc_bus_responder: TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ARMED, S_WRITE, S_READ, S_DRAIN} state_t;
  state_t state, state_n;

  // ---------------- input synchronizers ----------------
  logic [SYNC-1:0]       cs_sy, ph_sy, wr_sy, rd_sy;
  logic [SYNC-1:0][7:0]  ad_sy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sy <= '1;
      wr_sy <= '1;
      rd_sy <= '1;
      ph_sy <= '0;
      ad_sy <= '0;
    end else begin
      cs_sy <= {cs_sy[SYNC-2:0], bus.cs_n};
      ph_sy <= {ph_sy[SYNC-2:0], bus.a_d};
      wr_sy <= {wr_sy[SYNC-2:0], bus.wr_n};
      rd_sy <= {rd_sy[SYNC-2:0], bus.rd_n};
      ad_sy <= {ad_sy[SYNC-2:0], ad};
    end
  end

  logic       s_cs_n, s_a_d, s_wr_n, s_rd_n;
  logic [7:0] s_ad;
  assign s_cs_n = cs_sy[SYNC-1];
  assign s_a_d  = ph_sy[SYNC-1];
  assign s_wr_n = wr_sy[SYNC-1];
  assign s_rd_n = rd_sy[SYNC-1];
  assign s_ad   = ad_sy[SYNC-1];

  logic aw, dw, dr, conflict;
  assign aw       = !s_cs_n && !s_wr_n && !s_a_d;
  assign dw       = !s_cs_n && !s_wr_n &&  s_a_d;
  assign dr       = !s_cs_n && !s_rd_n &&  s_a_d;
  assign conflict = !s_cs_n && !s_wr_n && !s_rd_n;

  // ---------------- datapath state ----------------
  logic [NREG-1:0][7:0] regs;
  logic [7:0]           cap;      // last value sampled during a strobe
  logic [7:0]           rd_data;  // frozen on READ entry
  logic                 viol_q;

  logic [IW-1:0] bidx, lidx;
  logic          bus_in_rng, loc_in_rng;
  assign bidx       = bus_addr[IW-1:0];
  assign lidx       = loc_addr[IW-1:0];
  assign bus_in_rng = {1'b0, bus_addr} < 9'(NREG);
  assign loc_in_rng = {1'b0, loc_addr} < 9'(NREG);

  // A held violation (conflict, or a data strobe seen while IDLE) keeps
  // asserting every cycle.  Only its first cycle raises bus_err, so one bad
  // strobe gives one pulse.
  logic viol;
  assign viol = conflict || ((state == S_IDLE) && (dw || dr));

`ifdef RTC_RESP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;
  logic          to_hit;

  // Cleared whenever not ARMED, so the count starts at ARMED entry.
  // A re-address goes through ADDR and therefore restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                to_cnt <= '0;
    else if (state != S_ARMED) to_cnt <= '0;
    else                      to_cnt <= to_cnt + 1'b1;
  end
  assign to_hit = (to_cnt == CW'(TIMEOUT - 1));
`endif

  // ---------------- FSM next state / controls ----------------
  logic cap_ld, addr_ld, rd_ld, commit, err_n;

  always_comb begin
    state_n = state;
    cap_ld  = 1'b0;
    addr_ld = 1'b0;
    rd_ld   = 1'b0;
    commit  = 1'b0;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (aw) begin
          cap_ld  = 1'b1;
          state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        cap_ld = aw;
        if (!aw) begin
          addr_ld = 1'b1;
          state_n = S_ARMED;
        end
      end
      S_ARMED: begin
        if (aw) begin
          cap_ld  = 1'b1;
          state_n = S_ADDR;
        end else if (dw) begin
          cap_ld  = 1'b1;
          state_n = S_WRITE;
        end else if (dr) begin
          rd_ld   = 1'b1;
          err_n   = !bus_in_rng;
          state_n = S_READ;
        end
`ifdef RTC_RESP_TIMEOUT_EN
        else if (to_hit) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
`endif
      end
      S_WRITE: begin
        cap_ld = dw;
        if (!dw) begin
          commit  = bus_in_rng;
          err_n   = !bus_in_rng;
          state_n = S_IDLE;
        end
      end
      S_READ:  if (!dr) state_n = S_DRAIN;
      S_DRAIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // A conflict aborts whatever is in flight.  Nothing is written or latched.
    if (conflict) begin
      state_n = S_IDLE;
      cap_ld  = 1'b0;
      addr_ld = 1'b0;
      rd_ld   = 1'b0;
      commit  = 1'b0;
    end
    if (viol && !viol_q) err_n = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      bus_wr   <= 1'b0;
      bus_err  <= 1'b0;
      viol_q   <= 1'b0;
      cap      <= '0;
      bus_addr <= '0;
      rd_data  <= '0;
    end else begin
      state   <= state_n;
      bus_wr  <= commit;
      bus_err <= err_n;
      viol_q  <= viol;
      if (cap_ld)  cap      <= s_ad;
      if (addr_ld) bus_addr <= cap;
      if (rd_ld)   rd_data  <= bus_in_rng ? regs[bidx] : 8'h00;
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs      <= '0;
      loc_rdata <= '0;
    end else begin
      if (commit) regs[bidx] <= cap;
      // A bus commit to the same register wins over the local write.
      if (loc_we && loc_in_rng && !(commit && (bus_addr == loc_addr)))
        regs[lidx] <= loc_wdata;
      loc_rdata <= loc_in_rng ? regs[lidx] : 8'h00;
    end
  end

  // ---------------- bus drive ----------------
  logic ad_oe;
  assign ad_oe = (state == S_READ) || (state == S_DRAIN);
  assign ad    = ad_oe ? rd_data : 8'hzz;

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Device-side end of the multiplexed address/data RTC bus (cs_n, a_d, wr_n, rd_n, 8-bit ad). It decodes address and data phases issued by the controller-side write/read sequencer, holds a register file of NREG bytes, and returns read data on the shared bus. It serves as a synthesizable RTC stand-in for bring-up and as the bus-facing front of on-chip timekeeping logic, which updates registers through a local write port.

## Interface
- NREG, 16: number of 8-bit registers; addresses 0..NREG-1 valid, NREG ≤ 256.
- SYNC, 2: synchronizer depth on all bus inputs, min 2.
- TIMEOUT, 63: cycles allowed between address phase and data phase (macro-gated).

- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high.
- cs_n  in  1  bus chip select, active low.
- a_d  in  1  bus phase: 0 address, 1 data.
- wr_n  in  1  bus write strobe, active low.
- rd_n  in  1  bus read strobe, active low; undriven (z) reads as 1 via board pull-up.
- ad  inout  8  multiplexed address/data bus.
- loc_we  in  1  local register write strobe.
- loc_addr  in  8  local register address.
- loc_wdata  in  8  local write data.
- loc_rdata  out  8  registered contents of reg[loc_addr].
- bus_wr  out  1  one-cycle pulse: bus write committed.
- bus_addr  out  8  last latched bus address.
- bus_err  out  1  one-cycle pulse: protocol violation.

## Operation
- cs_n, a_d, wr_n, rd_n, ad pass through SYNC flops; all decoding uses synchronized copies (s_*).
- Strobe qualifiers: AW = !s_cs_n & !s_wr_n & !s_a_d; DW = !s_cs_n & !s_wr_n & s_a_d; DR = !s_cs_n & !s_rd_n & s_a_d; CONFLICT = !s_cs_n & !s_wr_n & !s_rd_n.
- States: IDLE, ADDR, ARMED, WRITE, READ, DRAIN.
- IDLE: AW → ADDR. DW or DR → bus_err, stay.
- ADDR: s_ad captured every cycle; on AW release, bus_addr ← last captured value → ARMED.
- ARMED: AW → ADDR (re-address); DW → WRITE; DR → READ.
- WRITE: s_ad captured every cycle; on DW release, reg[bus_addr] ← last captured, bus_wr pulse → IDLE. Out-of-range address: no write, bus_err pulse, no bus_wr.
- READ: ad driven with rd_data, latched on READ entry = reg[bus_addr], or 0x00 if out of range (plus bus_err). On DR release → DRAIN.
- DRAIN: ad kept driven one cycle → IDLE.
- CONFLICT in any state: bus_err pulse, → IDLE, ad released, no write.
- ad is driven only in READ and DRAIN; otherwise z.
- Local port: loc_we writes reg[loc_addr] if in range. Same-cycle bus commit to same address: bus wins, local write dropped. loc_rdata = reg[loc_addr] registered, 0x00 if out of range.

## Timing
- Reset: state IDLE, all regs 0x00, bus_addr 0x00, loc_rdata 0x00, bus_wr 0, bus_err 0, ad z.
- Input-to-decode latency SYNC cycles; commit (bus_wr) SYNC+1 cycles after raw wr_n/cs_n rise.
- ad drive starts SYNC+1 cycles after raw rd_n fall; released SYNC+2 cycles after raw rd_n rise.
- Minimum strobe width SYNC+1 cycles; minimum gap between phases 2 cycles.
- Controller sequence (2/8/2/11/8/3 cycles) satisfied with SYNC=2; read data valid on ad by raw strobe cycle 3, held until ≥2 cycles after strobe release.
- Reset mid-phase: immediate IDLE, ad z, pending write discarded.

## Configuration
- RTC_RESP_TIMEOUT_EN defined: counter starts on ARMED entry; reaching TIMEOUT cycles without DW/DR/AW → bus_err pulse, → IDLE.
- Undefined: ARMED waits indefinitely; no counter logic present.

## Test plan
- Write: address phase 0x05, data phase 0xA7 → bus_wr pulse once, reg[5]=0xA7, loc_addr=5 gives loc_rdata=0xA7.
- Read: loc write reg[3]=0x3C, bus read address 0x03 → ad=0x3C during rd_n low and 2 cycles after, then z.
- Out of range: write address 0x20 (NREG=16) data 0x11 → bus_err pulse, no bus_wr; read 0x20 → ad=0x00, bus_err.
- Conflict: cs_n, wr_n, rd_n all low → bus_err, state IDLE, no register changes.
- Collision: bus commit 0x55 and loc_we 0xAA to reg[7] same cycle → reg[7]=0x55.
- Timeout (macro on, TIMEOUT=63): address phase only, idle 64 cycles → bus_err pulse; subsequent data phase ignored with bus_err.
